// File: rtl/butterfly_display_if.sv
// Bundle between the butterfly controller/datapath and the display stage.
// Master drives results, selects and clear; slave returns segments and busy.
interface butterfly_display_if #(
  parameter int W = 16
);
  logic         clear;
  logic         display_ReY;
  logic         display_ImY;
  logic         display_ReZ;
  logic         display_ImZ;
  logic [W-1:0] ReY;
  logic [W-1:0] ImY;
  logic [W-1:0] ReZ;
  logic [W-1:0] ImZ;
  logic [6:0]   HEX0;
  logic [6:0]   HEX1;
  logic [6:0]   HEX2;
  logic [6:0]   HEX3;
  logic [6:0]   HEX4;
  logic [6:0]   HEX5;
  logic         busy;

  modport master (
    output clear,
    output display_ReY, display_ImY,
    output display_ReZ, display_ImZ,
    output ReY, ImY, ReZ, ImZ,
    input  HEX0, HEX1, HEX2,
    input  HEX3, HEX4, HEX5,
    input  busy
  );

  modport slave (
    input  clear,
    input  display_ReY, display_ImY,
    input  display_ReZ, display_ImZ,
    input  ReY, ImY, ReZ, ImZ,
    output HEX0, HEX1, HEX2,
    output HEX3, HEX4, HEX5,
    output busy
  );
endinterface

// File: rtl/butterfly_display.sv
// Butterfly result display: signed value -> sign + 5 BCD digits on 7-seg.
// Ports: Clock, nReset, bus (slave: selects/values/clear in, HEX0..5/busy out).
module butterfly_display #(
  parameter int W = 16
) (
  input logic          Clock,
  input logic          nReset,
  butterfly_display_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPDATE
  } state_t;

  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] MINUS = 7'b0111111;

  state_t state;
  state_t stateNext;

  logic         anySel;
  logic [1:0]   selCode;
  logic [W-1:0] selVal;
  logic [W+1:0] reqWord;
  logic [W-1:0] absVal;

  logic [W+1:0] tag;
  logic         tagValid;
  logic [W-1:0] mag;
  logic         neg;
  logic [19:0]  bcd;
  logic [4:0]   cnt;
  logic [6:0]   hex [6];

  logic         abort;
  logic         start;
  logic         shiftDone;

  logic [19:0]  bcdAdj;
  logic [19:0]  bcdNext;
  logic [W-1:0] magNext;
  logic [6:0]   hexNext [6];
  logic         lead;
  logic         busyOut;

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = BLANK;
    endcase
    return s;
  endfunction

  // Fixed priority ReY > ImY > ReZ > ImZ
  always_comb begin
    anySel  = 1'b1;
    selCode = 2'd0;
    selVal  = bus.ImZ;
    priority case (1'b1)
      bus.display_ReY: begin
        selCode = 2'd0;
        selVal  = bus.ReY;
      end
      bus.display_ImY: begin
        selCode = 2'd1;
        selVal  = bus.ImY;
      end
      bus.display_ReZ: begin
        selCode = 2'd2;
        selVal  = bus.ReZ;
      end
      bus.display_ImZ: begin
        selCode = 2'd3;
        selVal  = bus.ImZ;
      end
      default: anySel = 1'b0;
    endcase
  end

  assign reqWord = {selCode, selVal};

  // Most-negative input wraps to 2^(W-1), which is correct as unsigned
  assign absVal = selVal[W-1] ?
                  (~selVal + W'(1)) : selVal;

  assign abort = bus.clear | ~anySel;

  assign start = (state == IDLE) & ~abort &
                 (~tagValid | (reqWord != tag));

  assign shiftDone = (state == SHIFT) &
                     (cnt == 5'(W - 1));

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    if (abort) begin
      stateNext = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start) stateNext = SHIFT;
        SHIFT:   if (shiftDone) stateNext = UPDATE;
        UPDATE:  stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    busyOut = (state != IDLE);

    bcdAdj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcdAdj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    bcdNext = {bcdAdj[18:0], mag[W-1]};
    magNext = {mag[W-2:0], 1'b0};

    // Blank leading zeros from the top; digit 0 always shows
    lead = 1'b1;
    for (int i = 0; i < 6; i++) begin
      hexNext[i] = BLANK;
    end
    for (int i = 4; i >= 0; i--) begin
      if (lead && (bcd[4*i +: 4] == 4'd0) && (i != 0)) begin
        hexNext[i] = BLANK;
      end else begin
        lead       = 1'b0;
        hexNext[i] = seg(bcd[4*i +: 4]);
      end
    end
    // A negative input is never zero in magnitude
    hexNext[5] = neg ? MINUS : BLANK;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      tag      <= '0;
      tagValid <= 1'b0;
      mag      <= '0;
      neg      <= 1'b0;
      bcd      <= '0;
      cnt      <= '0;
      for (int i = 0; i < 6; i++) begin
        hex[i] <= BLANK;
      end
    end else if (abort) begin
      tagValid <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        hex[i] <= BLANK;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            tag      <= reqWord;
            tagValid <= 1'b1;
            mag      <= absVal;
            neg      <= selVal[W-1];
            bcd      <= '0;
            cnt      <= '0;
          end
        end
        SHIFT: begin
          bcd <= bcdNext;
          mag <= magNext;
          cnt <= cnt + 5'd1;
        end
        UPDATE: begin
          for (int i = 0; i < 6; i++) begin
            hex[i] <= hexNext[i];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.HEX0 = hex[0];
  assign bus.HEX1 = hex[1];
  assign bus.HEX2 = hex[2];
  assign bus.HEX3 = hex[3];
  assign bus.HEX4 = hex[4];
  assign bus.HEX5 = hex[5];
  assign bus.busy = busyOut;

endmodule

// File: tb/tb_butterfly_display.sv
// Directed bench for butterfly_display at W=16.
// Drives selects/values via the interface and checks HEX and busy.
module tb_butterfly_display;

  logic Clock;
  logic nReset;
  int   tests;
  int   failed;
  int   n;

  butterfly_display_if #(.W(16)) bus ();

  butterfly_display #(.W(16)) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic checkHex(
    input string      tag,
    input logic [6:0] e5,
    input logic [6:0] e4,
    input logic [6:0] e3,
    input logic [6:0] e2,
    input logic [6:0] e1,
    input logic [6:0] e0
  );
    check({tag, ".HEX5"}, 32'(bus.HEX5), 32'(e5));
    check({tag, ".HEX4"}, 32'(bus.HEX4), 32'(e4));
    check({tag, ".HEX3"}, 32'(bus.HEX3), 32'(e3));
    check({tag, ".HEX2"}, 32'(bus.HEX2), 32'(e2));
    check({tag, ".HEX1"}, 32'(bus.HEX1), 32'(e1));
    check({tag, ".HEX0"}, 32'(bus.HEX0), 32'(e0));
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // One capture edge, then count cycles while busy (bounded)
  task automatic run(output int cnt);
    tick();
    cnt = 0;
    while (bus.busy && cnt < 40) begin
      cnt++;
      tick();
    end
  endtask

  task automatic sel(input logic [3:0] s);
    bus.display_ReY = s[3];
    bus.display_ImY = s[2];
    bus.display_ReZ = s[1];
    bus.display_ImZ = s[0];
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    nReset = 1'b0;
    bus.clear = 1'b0;
    sel(4'b0000);
    bus.ReY = '0;
    bus.ImY = '0;
    bus.ReZ = '0;
    bus.ImZ = '0;

    repeat (2) tick();
    checkHex("rst", 7'h7F, 7'h7F, 7'h7F,
             7'h7F, 7'h7F, 7'h7F);
    check("rst.busy", 32'(bus.busy), 32'd0);
    nReset = 1'b1;
    repeat (6) tick();
    checkHex("idle", 7'h7F, 7'h7F, 7'h7F,
             7'h7F, 7'h7F, 7'h7F);
    check("idle.busy", 32'(bus.busy), 32'd0);

    // 1234
    sel(4'b1000);
    bus.ReY = 16'd1234;
    run(n);
    check("1234.busyLen", 32'(n), 32'd17);
    checkHex("1234", 7'h7F, 7'h7F, 7'h79,
             7'h24, 7'h30, 7'h19);
    repeat (4) tick();
    check("1234.noRetrig", 32'(bus.busy), 32'd0);

    // -32768
    sel(4'b0100);
    bus.ImY = 16'h8000;
    run(n);
    check("min.busyLen", 32'(n), 32'd17);
    checkHex("min", 7'h3F, 7'h30, 7'h24,
             7'h78, 7'h02, 7'h00);

    // 0
    bus.ImY = 16'd0;
    run(n);
    checkHex("zero", 7'h7F, 7'h7F, 7'h7F,
             7'h7F, 7'h7F, 7'h40);

    // -1 and 32767
    bus.ImY = 16'hFFFF;
    run(n);
    checkHex("neg1", 7'h3F, 7'h7F, 7'h7F,
             7'h7F, 7'h7F, 7'h79);
    bus.ImY = 16'd32767;
    run(n);
    checkHex("max", 7'h7F, 7'h30, 7'h24,
             7'h78, 7'h02, 7'h78);

    // Input change mid-conversion
    sel(4'b1000);
    bus.ReY = 16'd5;
    tick();
    repeat (3) tick();
    bus.ReY = 16'd77;
    check("chg.holdOld", 32'(bus.HEX0), 32'h78);
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      tick();
    end
    check("chg.firstLen", 32'(n), 32'd14);
    checkHex("chg5", 7'h7F, 7'h7F, 7'h7F,
             7'h7F, 7'h7F, 7'h12);
    run(n);
    check("chg.secondLen", 32'(n), 32'd17);
    checkHex("chg77", 7'h7F, 7'h7F, 7'h7F,
             7'h7F, 7'h78, 7'h78);

    // Priority
    sel(4'b1010);
    bus.ReY = 16'd9;
    bus.ReZ = 16'd4;
    run(n);
    checkHex("prio9", 7'h7F, 7'h7F, 7'h7F,
             7'h7F, 7'h7F, 7'h10);
    sel(4'b0010);
    run(n);
    check("prio4.busyLen", 32'(n), 32'd17);
    checkHex("prio4", 7'h7F, 7'h7F, 7'h7F,
             7'h7F, 7'h7F, 7'h19);

    // Clear mid-conversion
    bus.ReZ = 16'd321;
    tick();
    repeat (7) tick();
    bus.clear = 1'b1;
    tick();
    checkHex("clr", 7'h7F, 7'h7F, 7'h7F,
             7'h7F, 7'h7F, 7'h7F);
    check("clr.busy", 32'(bus.busy), 32'd0);
    bus.clear = 1'b0;
    run(n);
    check("clr.restartLen", 32'(n), 32'd17);
    checkHex("clr321", 7'h7F, 7'h7F, 7'h7F,
             7'h30, 7'h24, 7'h79);

    // Deselect blanks; reselecting same value converts again
    sel(4'b0000);
    tick();
    checkHex("desel", 7'h7F, 7'h7F, 7'h7F,
             7'h7F, 7'h7F, 7'h7F);
    sel(4'b0010);
    run(n);
    check("resel.busyLen", 32'(n), 32'd17);
    check("resel.HEX0", 32'(bus.HEX0), 32'h79);

    // Reset mid-conversion
    bus.ReZ = 16'd42;
    tick();
    repeat (5) tick();
    nReset = 1'b0;
    #1;
    check("arst.busy", 32'(bus.busy), 32'd0);
    check("arst.HEX0", 32'(bus.HEX0), 32'h7F);
    nReset = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed",
             tests, failed);
    $finish;
  end

endmodule
